// File: rtl/pa_uart_rx_mon.sv
`default_nettype none
//==============================================================================
//  Module      : pa_uart_rx_mon
//  Description : UART receive monitor. Oversamples the asynchronous rxd line
//                with a single baud counter, frames DATA_BITS payload bits with
//                optional parity and one or two stop bits, queues good
//                characters into a small FIFO with a valid/ready read port and
//                keeps sticky frame/parity/overrun flags plus a character count.
//  Revision    : 1.0  initial release
//==============================================================================
module pa_uart_rx_mon #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        rxd,
   input  logic        clr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [7:0]  data_o,
   output logic        frame_err_o,
   output logic        parity_err_o,
   output logic        overrun_o,
   output logic [15:0] char_cnt_o
);

   // Clock cycles per bit and derived widths.
   localparam int c_DIV   = CLK_FREQ_HZ / BAUD;
   localparam int c_CNT_W = $clog2(c_DIV);
   localparam int c_AW    = $clog2(FIFO_DEPTH);
   localparam int c_PW    = c_AW + 1;

   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_DIV / 2);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [2:0]         c_BIT_LAST = 3'(DATA_BITS - 1);
   localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [c_PW-1:0]    c_PTR_ONE  = c_PW'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Line synchronizer and edge history.
   logic               r_rxd_s1;
   logic               r_rxd_s2;
   logic               r_rxd_prev;
   logic               w_rx;

   // Frame receiver.
   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic               r_stop_idx;
   logic [7:0]         r_shift;
   logic               r_par_bad;
   logic               r_stop_bad;
   logic               w_tick;
   logic               w_par_exp;

   // Frame-end events, registered one cycle after the last stop sample.
   logic               r_push_req;
   logic               r_ferr_evt;
   logic               r_perr_evt;

   // Receive FIFO.
   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_PW-1:0]    r_wr_ptr;
   logic [c_PW-1:0]    r_rd_ptr;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_ovr_evt;

   assign w_rx   = r_rxd_s2;
   assign w_tick = (r_cnt == c_CNT_LAST);

   // Expected parity bit computed from the payload collected so far; the
   // shift register is cleared at frame start so unused upper bits are 0.
   generate
      if (PARITY == 1) begin : g_par_odd
         assign w_par_exp = ~(^r_shift);
      end else begin : g_par_even
         assign w_par_exp = ^r_shift;
      end
   endgenerate

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rxd_s1   <= 1'b1;
         r_rxd_s2   <= 1'b1;
         r_rxd_prev <= 1'b1;
      end else begin
         r_rxd_s1   <= rxd;
         r_rxd_s2   <= r_rxd_s1;
         r_rxd_prev <= r_rxd_s2;
      end
   end

   // Receive state machine: start validation, mid-bit sampling, frame-end events.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_par_bad  <= 1'b0;
         r_stop_bad <= 1'b0;
         r_push_req <= 1'b0;
         r_ferr_evt <= 1'b0;
         r_perr_evt <= 1'b0;
      end else begin
         r_push_req <= 1'b0;
         r_ferr_evt <= 1'b0;
         r_perr_evt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               // Only a true 1->0 transition starts a frame, so a line stuck
               // low after a broken frame must go high again first.
               if (r_rxd_prev && !w_rx) begin
                  r_state    <= ST_START;
                  r_shift    <= '0;
                  r_bit_idx  <= '0;
                  r_stop_idx <= 1'b0;
                  r_par_bad  <= 1'b0;
                  r_stop_bad <= 1'b0;
               end
            end
            ST_START: begin
               if (r_cnt == c_CNT_HALF) begin
                  // Restarting here puts every later sample mid-bit.
                  r_cnt   <= '0;
                  r_state <= w_rx ? ST_IDLE : ST_DATA;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_cnt              <= '0;
                  r_shift[r_bit_idx] <= w_rx;
                  if (r_bit_idx == c_BIT_LAST) begin
                     r_bit_idx <= '0;
                     r_state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_cnt     <= '0;
                  r_par_bad <= (w_rx != w_par_exp);
                  r_state   <= ST_STOP;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  r_cnt <= '0;
                  if (r_stop_idx == c_STOP_LAST) begin
                     r_state    <= ST_IDLE;
                     r_perr_evt <= r_par_bad;
                     if (r_stop_bad || !w_rx) begin
                        r_ferr_evt <= 1'b1;
                     end else begin
                        r_push_req <= 1'b1;
                     end
                  end else begin
                     r_stop_idx <= 1'b1;
                     if (!w_rx) begin
                        r_stop_bad <= 1'b1;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // FIFO status: pointers carry one extra wrap bit to tell full from empty.
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop     = !w_empty && ready_i;
   // A pop in the same cycle frees the slot the new character needs.
   assign w_push    = r_push_req && (!w_full || w_pop);
   assign w_ovr_evt = r_push_req && w_full && !w_pop;

   assign valid_o = !w_empty;
   assign data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];

   // FIFO storage; contents are only visible through data_o while non-empty.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
      end
   end

   // FIFO pointers and character counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         char_cnt_o <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
            char_cnt_o <= char_cnt_o + 16'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   // Sticky error flags; a new event outranks a simultaneous clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         if (r_ferr_evt) begin
            frame_err_o <= 1'b1;
         end else if (clr_i) begin
            frame_err_o <= 1'b0;
         end
         if (r_perr_evt) begin
            parity_err_o <= 1'b1;
         end else if (clr_i) begin
            parity_err_o <= 1'b0;
         end
         if (w_ovr_evt) begin
            overrun_o <= 1'b1;
         end else if (clr_i) begin
            overrun_o <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pa_uart_rx_mon.sv
`default_nettype none
//==============================================================================
//  Module      : tb_pa_uart_rx_mon
//  Description : Self-checking bench for pa_uart_rx_mon. Four instances cover
//                8N1/depth 16, even parity, depth 4 and 5-bit/2-stop framing.
//  Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
module tb_pa_uart_rx_mon;

   localparam int DIV = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rxd_v   [4];
   logic        ready_v [4];
   logic        clr_v   [4];
   logic        valid_v [4];
   logic [7:0]  data_v  [4];
   logic        ferr_v  [4];
   logic        perr_v  [4];
   logic        ovr_v   [4];
   logic [15:0] cnt_v   [4];
   logic [15:0] exp_cnt [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pa_uart_rx_mon #(.CLK_FREQ_HZ(50_000_000), .BAUD(5_000_000)) u_dut_8n1 (
      .clk_i(clk), .rst_n_i(rst_n), .rxd(rxd_v[0]), .clr_i(clr_v[0]), .ready_i(ready_v[0]),
      .valid_o(valid_v[0]), .data_o(data_v[0]), .frame_err_o(ferr_v[0]),
      .parity_err_o(perr_v[0]), .overrun_o(ovr_v[0]), .char_cnt_o(cnt_v[0]));

   pa_uart_rx_mon #(.CLK_FREQ_HZ(50_000_000), .BAUD(5_000_000), .PARITY(2)) u_dut_par (
      .clk_i(clk), .rst_n_i(rst_n), .rxd(rxd_v[1]), .clr_i(clr_v[1]), .ready_i(ready_v[1]),
      .valid_o(valid_v[1]), .data_o(data_v[1]), .frame_err_o(ferr_v[1]),
      .parity_err_o(perr_v[1]), .overrun_o(ovr_v[1]), .char_cnt_o(cnt_v[1]));

   pa_uart_rx_mon #(.CLK_FREQ_HZ(50_000_000), .BAUD(5_000_000), .FIFO_DEPTH(4)) u_dut_fifo4 (
      .clk_i(clk), .rst_n_i(rst_n), .rxd(rxd_v[2]), .clr_i(clr_v[2]), .ready_i(ready_v[2]),
      .valid_o(valid_v[2]), .data_o(data_v[2]), .frame_err_o(ferr_v[2]),
      .parity_err_o(perr_v[2]), .overrun_o(ovr_v[2]), .char_cnt_o(cnt_v[2]));

   pa_uart_rx_mon #(.CLK_FREQ_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(5),
                    .STOP_BITS(2)) u_dut_5b2 (
      .clk_i(clk), .rst_n_i(rst_n), .rxd(rxd_v[3]), .clr_i(clr_v[3]), .ready_i(ready_v[3]),
      .valid_o(valid_v[3]), .data_o(data_v[3]), .frame_err_o(ferr_v[3]),
      .parity_err_o(perr_v[3]), .overrun_o(ovr_v[3]), .char_cnt_o(cnt_v[3]));

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Read the head entry and accept it with a one-cycle ready pulse.
   task automatic pop_one(input int idx, output logic v, output logic [7:0] d);
      v = valid_v[idx];
      d = data_v[idx];
      ready_v[idx] = 1'b1;
      tick(1);
      ready_v[idx] = 1'b0;
   endtask

   task automatic pulse_clr(input int idx);
      clr_v[idx] = 1'b1;
      tick(1);
      clr_v[idx] = 1'b0;
   endtask

   // Serialise one frame, DIV cycles per bit; cut>0 abandons after cut cycles.
   task automatic send_frame(input int idx, input logic [7:0] d, input int nbits, input int par,
                             input bit bad_par, input logic [1:0] stops, input int nstop,
                             input int cut);
      logic [15:0] seq;
      logic [7:0]  m;
      logic        pb;
      int          n;
      int          el;
      m = d & 8'((1 << nbits) - 1);
      seq = '1;
      seq[0] = 1'b0;
      for (int i = 0; i < nbits; i++) seq[1+i] = m[i];
      n = 1 + nbits;
      if (par != 0) begin
         pb = (par == 2) ? ^m : ~^m;
         seq[n] = pb ^ bad_par;
         n++;
      end
      for (int s = 0; s < nstop; s++) seq[n+s] = stops[s];
      n += nstop;
      el = 0;
      for (int k = 0; k < n; k++) begin
         rxd_v[idx] = seq[k];
         for (int c = 0; c < DIV; c++) begin
            @(posedge clk);
            el++;
            if (cut > 0 && el == cut) begin
               #1;
               return;
            end
         end
         #1;
      end
   endtask

   task automatic test_reset;
      tick(2);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({valid_v[i], data_v[i], ferr_v[i], perr_v[i], ovr_v[i], cnt_v[i]} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: observed %0h expected 0", i,
                     {valid_v[i], data_v[i], ferr_v[i], perr_v[i], ovr_v[i], cnt_v[i]});
         end
         exp_cnt[i] = 16'd0;
      end
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_8n1_single;
      logic       v;
      logic [7:0] d;
      fork
         send_frame(0, 8'h55, 8, 0, 1'b0, 2'b11, 1, 0);
         begin
            tick(9 + DIV * 9);
            n_checks++;
            if (valid_v[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL latency_at_stop: observed valid %0b expected 0", valid_v[0]);
            end
            tick(1);
            n_checks++;
            if (valid_v[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL latency_after_stop: observed valid %0b expected 1", valid_v[0]);
            end
         end
      join
      exp_cnt[0]++;
      n_checks++;
      if ({data_v[0], cnt_v[0], ferr_v[0], perr_v[0], ovr_v[0]} !== {8'h55, exp_cnt[0], 3'b000}) begin
         n_fail++;
         $display("FAIL single_55: observed data %0h cnt %0h flags %0b%0b%0b expected 55 %0h 000",
                  data_v[0], cnt_v[0], ferr_v[0], perr_v[0], ovr_v[0], exp_cnt[0]);
      end
      pop_one(0, v, d);
      n_checks++;
      if (valid_v[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pop_empty: observed valid %0b expected 0", valid_v[0]);
      end
   endtask

   task automatic test_random_8n1;
      logic [7:0] q[$];
      logic [7:0] b;
      logic [7:0] exp_d;
      logic       v;
      logic [7:0] d;
      for (int it = 0; it < 20; it++) begin
         b = 8'($urandom);
         send_frame(0, b, 8, 0, 1'b0, 2'b11, 1, 0);
         q.push_back(b);
         exp_cnt[0]++;
         n_checks++;
         if ({valid_v[0], data_v[0], cnt_v[0]} !== {1'b1, q[0], exp_cnt[0]}) begin
            n_fail++;
            $display("FAIL rand_head it%0d: observed v%0b d%0h c%0h expected v1 d%0h c%0h", it,
                     valid_v[0], data_v[0], cnt_v[0], q[0], exp_cnt[0]);
         end
         if (q.size() >= 12 || $urandom_range(0, 1) == 1) begin
            pop_one(0, v, d);
            exp_d = q.pop_front();
            n_checks++;
            if ({v, d} !== {1'b1, exp_d}) begin
               n_fail++;
               $display("FAIL rand_pop it%0d: observed v%0b d%0h expected v1 d%0h", it, v, d, exp_d);
            end
         end
      end
      while (q.size() > 0) begin
         pop_one(0, v, d);
         exp_d = q.pop_front();
         n_checks++;
         if ({v, d} !== {1'b1, exp_d}) begin
            n_fail++;
            $display("FAIL rand_drain: observed v%0b d%0h expected v1 d%0h", v, d, exp_d);
         end
      end
      n_checks++;
      if ({valid_v[0], ferr_v[0], perr_v[0], ovr_v[0]} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rand_final: observed %0b expected 0000",
                  {valid_v[0], ferr_v[0], perr_v[0], ovr_v[0]});
      end
   endtask

   task automatic test_parity;
      logic       v;
      logic [7:0] d;
      logic [7:0] b;
      bit         flip;
      send_frame(1, 8'h07, 8, 2, 1'b1, 2'b11, 1, 0);
      exp_cnt[1]++;
      n_checks++;
      if ({data_v[1], perr_v[1], ferr_v[1], cnt_v[1]} !== {8'h07, 1'b1, 1'b0, exp_cnt[1]}) begin
         n_fail++;
         $display("FAIL parity_07: observed d%0h p%0b f%0b c%0h expected d07 p1 f0 c%0h",
                  data_v[1], perr_v[1], ferr_v[1], cnt_v[1], exp_cnt[1]);
      end
      pulse_clr(1);
      n_checks++;
      if (perr_v[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_clr: observed %0b expected 0", perr_v[1]);
      end
      pop_one(1, v, d);
      fork
         send_frame(1, 8'h07, 8, 2, 1'b1, 2'b11, 1, 0);
         begin
            tick(9 + DIV * 10);
            clr_v[1] = 1'b1;
            tick(1);
            clr_v[1] = 1'b0;
         end
      join
      exp_cnt[1]++;
      n_checks++;
      if (perr_v[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_set_beats_clr: observed %0b expected 1", perr_v[1]);
      end
      pulse_clr(1);
      pop_one(1, v, d);
      for (int it = 0; it < 8; it++) begin
         b = 8'($urandom);
         flip = 1'($urandom_range(0, 1));
         send_frame(1, b, 8, 2, flip, 2'b11, 1, 0);
         exp_cnt[1]++;
         n_checks++;
         if ({valid_v[1], data_v[1], perr_v[1], cnt_v[1]} !== {1'b1, b, flip, exp_cnt[1]}) begin
            n_fail++;
            $display("FAIL parity_rand it%0d: observed v%0b d%0h p%0b c%0h expected v1 d%0h p%0b c%0h",
                     it, valid_v[1], data_v[1], perr_v[1], cnt_v[1], b, flip, exp_cnt[1]);
         end
         pulse_clr(1);
         pop_one(1, v, d);
      end
   endtask

   task automatic test_frame_err;
      logic       v;
      logic [7:0] d;
      send_frame(0, 8'hA3, 8, 0, 1'b0, 2'b00, 1, 0);
      n_checks++;
      if ({valid_v[0], ferr_v[0], cnt_v[0]} !== {1'b0, 1'b1, exp_cnt[0]}) begin
         n_fail++;
         $display("FAIL frame_err_a3: observed v%0b f%0b c%0h expected v0 f1 c%0h",
                  valid_v[0], ferr_v[0], cnt_v[0], exp_cnt[0]);
      end
      // Line stays low well past a frame time before going idle.
      tick(120);
      rxd_v[0] = 1'b1;
      tick(5);
      pulse_clr(0);
      n_checks++;
      if ({valid_v[0], ferr_v[0]} !== 2'b00) begin
         n_fail++;
         $display("FAIL frame_err_clr: observed %0b expected 00", {valid_v[0], ferr_v[0]});
      end
      send_frame(0, 8'h5A, 8, 0, 1'b0, 2'b11, 1, 0);
      exp_cnt[0]++;
      n_checks++;
      if ({valid_v[0], data_v[0], ferr_v[0], cnt_v[0]} !== {1'b1, 8'h5A, 1'b0, exp_cnt[0]}) begin
         n_fail++;
         $display("FAIL frame_err_recover: observed v%0b d%0h f%0b c%0h expected v1 d5a f0 c%0h",
                  valid_v[0], data_v[0], ferr_v[0], cnt_v[0], exp_cnt[0]);
      end
      pop_one(0, v, d);
   endtask

   task automatic test_overrun;
      logic [7:0] q[$];
      logic       exp_ovr;
      logic       v;
      logic [7:0] d;
      logic [7:0] exp_d;
      exp_ovr = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         send_frame(2, 8'(k), 8, 0, 1'b0, 2'b11, 1, 0);
         if (q.size() < 4) begin
            q.push_back(8'(k));
            exp_cnt[2]++;
         end else begin
            exp_ovr = 1'b1;
         end
      end
      n_checks++;
      if ({ovr_v[2], cnt_v[2]} !== {exp_ovr, exp_cnt[2]}) begin
         n_fail++;
         $display("FAIL overrun_full: observed o%0b c%0h expected o%0b c%0h",
                  ovr_v[2], cnt_v[2], exp_ovr, exp_cnt[2]);
      end
      while (q.size() > 0) begin
         pop_one(2, v, d);
         exp_d = q.pop_front();
         n_checks++;
         if ({v, d} !== {1'b1, exp_d}) begin
            n_fail++;
            $display("FAIL overrun_drain: observed v%0b d%0h expected v1 d%0h", v, d, exp_d);
         end
      end
      pulse_clr(2);
      n_checks++;
      if ({valid_v[2], ovr_v[2]} !== 2'b00) begin
         n_fail++;
         $display("FAIL overrun_clr: observed %0b expected 00", {valid_v[2], ovr_v[2]});
      end
      for (int k = 1; k <= 4; k++) begin
         send_frame(2, 8'(k), 8, 0, 1'b0, 2'b11, 1, 0);
         q.push_back(8'(k));
         exp_cnt[2]++;
      end
      fork
         send_frame(2, 8'h05, 8, 0, 1'b0, 2'b11, 1, 0);
         begin
            tick(9 + DIV * 9);
            ready_v[2] = 1'b1;
            tick(1);
            ready_v[2] = 1'b0;
         end
      join
      exp_d = q.pop_front();
      q.push_back(8'h05);
      exp_cnt[2]++;
      n_checks++;
      if ({ovr_v[2], cnt_v[2]} !== {1'b0, exp_cnt[2]}) begin
         n_fail++;
         $display("FAIL overrun_with_pop: observed o%0b c%0h expected o0 c%0h",
                  ovr_v[2], cnt_v[2], exp_cnt[2]);
      end
      while (q.size() > 0) begin
         pop_one(2, v, d);
         exp_d = q.pop_front();
         n_checks++;
         if ({v, d} !== {1'b1, exp_d}) begin
            n_fail++;
            $display("FAIL overrun_pop_drain: observed v%0b d%0h expected v1 d%0h", v, d, exp_d);
         end
      end
   endtask

   task automatic test_glitch;
      rxd_v[0] = 1'b0;
      tick(3);
      rxd_v[0] = 1'b1;
      tick(30);
      n_checks++;
      if ({valid_v[0], ferr_v[0], perr_v[0], ovr_v[0], cnt_v[0]} !== {4'b0000, exp_cnt[0]}) begin
         n_fail++;
         $display("FAIL glitch: observed v%0b f%0b p%0b o%0b c%0h expected 0000 c%0h",
                  valid_v[0], ferr_v[0], perr_v[0], ovr_v[0], cnt_v[0], exp_cnt[0]);
      end
   endtask

   task automatic test_five_bit;
      logic       v;
      logic [7:0] d;
      logic [7:0] b;
      send_frame(3, 8'h1F, 5, 0, 1'b0, 2'b11, 2, 0);
      exp_cnt[3]++;
      n_checks++;
      if ({valid_v[3], data_v[3], cnt_v[3]} !== {1'b1, 8'h1F, exp_cnt[3]}) begin
         n_fail++;
         $display("FAIL five_1f: observed v%0b d%0h c%0h expected v1 d1f c%0h",
                  valid_v[3], data_v[3], cnt_v[3], exp_cnt[3]);
      end
      pop_one(3, v, d);
      send_frame(3, 8'h1F, 5, 0, 1'b0, 2'b01, 2, 0);
      n_checks++;
      if ({valid_v[3], ferr_v[3], cnt_v[3]} !== {1'b0, 1'b1, exp_cnt[3]}) begin
         n_fail++;
         $display("FAIL five_stop2_low: observed v%0b f%0b c%0h expected v0 f1 c%0h",
                  valid_v[3], ferr_v[3], cnt_v[3], exp_cnt[3]);
      end
      rxd_v[3] = 1'b1;
      tick(5);
      pulse_clr(3);
      for (int it = 0; it < 5; it++) begin
         b = 8'($urandom_range(0, 31));
         send_frame(3, b, 5, 0, 1'b0, 2'b11, 2, 0);
         exp_cnt[3]++;
         n_checks++;
         if ({valid_v[3], data_v[3], ferr_v[3], cnt_v[3]} !== {1'b1, b, 1'b0, exp_cnt[3]}) begin
            n_fail++;
            $display("FAIL five_rand it%0d: observed v%0b d%0h f%0b c%0h expected v1 d%0h f0 c%0h",
                     it, valid_v[3], data_v[3], ferr_v[3], cnt_v[3], b, exp_cnt[3]);
         end
         pop_one(3, v, d);
      end
   endtask

   task automatic test_reset_mid_frame;
      send_frame(0, 8'hA3, 8, 0, 1'b0, 2'b00, 1, 0);
      rxd_v[0] = 1'b1;
      tick(3);
      send_frame(0, 8'h11, 8, 0, 1'b0, 2'b11, 1, 0);
      // Abandon a frame 5 cycles into data bit 4.
      send_frame(0, 8'hC6, 8, 0, 1'b0, 2'b11, 1, 55);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({valid_v[0], data_v[0], ferr_v[0], perr_v[0], ovr_v[0], cnt_v[0]} !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_mid_frame: observed %0h expected 0",
                  {valid_v[0], data_v[0], ferr_v[0], perr_v[0], ovr_v[0], cnt_v[0]});
      end
      for (int i = 0; i < 4; i++) begin
         rxd_v[i] = 1'b1;
         exp_cnt[i] = 16'd0;
      end
      tick(2);
      rst_n = 1'b1;
      tick(3);
      n_checks++;
      if ({valid_v[0], ferr_v[0], cnt_v[0]} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_release: observed %0h expected 0", {valid_v[0], ferr_v[0], cnt_v[0]});
      end
      send_frame(0, 8'h3C, 8, 0, 1'b0, 2'b11, 1, 0);
      exp_cnt[0]++;
      n_checks++;
      if ({valid_v[0], data_v[0], ferr_v[0], perr_v[0], ovr_v[0], cnt_v[0]} !==
          {1'b1, 8'h3C, 3'b000, exp_cnt[0]}) begin
         n_fail++;
         $display("FAIL after_reset_3c: observed v%0b d%0h f%0b%0b%0b c%0h expected v1 d3c 000 c%0h",
                  valid_v[0], data_v[0], ferr_v[0], perr_v[0], ovr_v[0], cnt_v[0], exp_cnt[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rxd_v[i]   = 1'b1;
         ready_v[i] = 1'b0;
         clr_v[i]   = 1'b0;
         exp_cnt[i] = 16'd0;
      end
      test_reset();
      test_8n1_single();
      test_random_8n1();
      test_parity();
      test_frame_err();
      test_overrun();
      test_glitch();
      test_five_bit();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
